// File: rtl/bcd_timer_counter.sv
// rtl/bcd_timer_counter.sv - multi-digit BCD timer/counter with run/stop/done control
module bcd_timer_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b0
) (
  input  logic                clock,
  input  logic                clearn,
  input  logic [4*DIGITS-1:0] data,
  input  logic                loadn,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic                en,
  output logic [4*DIGITS-1:0] digits,
  output logic                zero,
  output logic                tc,
  output logic                running,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   value_q, value_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic [W-1:0]   load_val, count_val;
  logic           all_zero, all_nine, terminal;

  // Per-digit clamp of the load value and the rippled next count value.
  always_comb begin
    logic       chain;
    logic [3:0] nib;
    logic [3:0] dnib;
    logic [3:0] nxt;
    load_val  = '0;
    count_val = '0;
    all_zero  = 1'b1;
    all_nine  = 1'b1;
    chain     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      nib  = value_q[4*k +: 4];
      dnib = data[4*k +: 4];
      load_val[4*k +: 4] = (dnib > 4'd9) ? 4'd9 : dnib;
      nxt = nib;
      if (chain) begin
        if (nib > 4'd9)
          nxt = 4'd9;
        else if (dir)
          nxt = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
        else
          nxt = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
      end
      count_val[4*k +: 4] = nxt;
      chain    = chain & (dir ? (nib == 4'd9) : (nib == 4'd0));
      all_zero = all_zero & (nib == 4'd0);
      all_nine = all_nine & (nib == 4'd9);
    end
  end

  assign terminal = dir ? all_nine : all_zero;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    done_d  = 1'b0;
    if (!loadn) begin
      value_d = load_val;
      if (state_q == ST_DONE)
        state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN)
        state_d = ST_IDLE;
    end else if (start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && en) begin
      if (terminal && (WRAP == 1'b0)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        value_d = count_val;
      end
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign digits  = value_q;
  assign zero    = all_zero;
  assign tc      = en && (state_q == ST_RUN) && terminal;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// tb/tb_bcd_timer_counter.sv - scoreboard bench for bcd_timer_counter, WRAP=0 and WRAP=1
module tb_bcd_timer_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic         clock = 1'b0;
  logic         clearn;
  logic [W-1:0] data;
  logic         loadn, start, stop, dir, en;
  logic [W-1:0] digits0, digits1;
  logic         zero0, tc0, running0, done0;
  logic         zero1, tc1, running1, done1;

  always #5 clock = ~clock;

  bcd_timer_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) u_dut0 (
    .clock(clock), .clearn(clearn), .data(data), .loadn(loadn), .start(start),
    .stop(stop), .dir(dir), .en(en), .digits(digits0), .zero(zero0), .tc(tc0),
    .running(running0), .done(done0)
  );

  bcd_timer_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) u_dut1 (
    .clock(clock), .clearn(clearn), .data(data), .loadn(loadn), .start(start),
    .stop(stop), .dir(dir), .en(en), .digits(digits1), .zero(zero1), .tc(tc1),
    .running(running1), .done(done1)
  );

  typedef struct {
    int           unit;
    int           cyc;
    logic [W-1:0] dg;
    logic         z, t, r, d;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: the value is a plain decimal integer.
  int mval[2];
  int mst[2];
  bit mdone[2];

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_dec(input logic [W-1:0] d);
    int v, p, n;
    v = 0;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      n = int'(d[4*k +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mval[u]  = 0;
      mst[u]   = S_IDLE;
      mdone[u] = 1'b0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    bit   term;
    for (int u = 0; u < 2; u++) begin
      term   = dir ? (mval[u] == MAXV) : (mval[u] == 0);
      e.unit = u;
      e.cyc  = cyc;
      e.dg   = to_bcd(mval[u]);
      e.z    = (mval[u] == 0);
      e.t    = en && (mst[u] == S_RUN) && term;
      e.r    = (mst[u] == S_RUN);
      e.d    = mdone[u];
      sbq.push_back(e);
    end
  endtask

  task automatic model_step();
    bit term;
    for (int u = 0; u < 2; u++) begin
      mdone[u] = 1'b0;
      if (!loadn) begin
        mval[u] = clamp_dec(data);
        if (mst[u] == S_DONE) mst[u] = S_IDLE;
      end else if (stop) begin
        if (mst[u] == S_RUN) mst[u] = S_IDLE;
      end else if (start && mst[u] != S_RUN) begin
        mst[u] = S_RUN;
      end else if (mst[u] == S_RUN && en) begin
        term = dir ? (mval[u] == MAXV) : (mval[u] == 0);
        if (term && u == 0) begin
          mst[u]   = S_DONE;
          mdone[u] = 1'b1;
        end else if (dir) begin
          mval[u] = (mval[u] + 1) % (MAXV + 1);
        end else begin
          mval[u] = (mval[u] + MAXV) % (MAXV + 1);
        end
      end
    end
  endtask

  task automatic cycle(input logic l_n, input logic [W-1:0] d, input logic s,
                       input logic sp, input logic dr, input logic e);
    loadn = l_n;
    data  = d;
    start = s;
    stop  = sp;
    dir   = dr;
    en    = e;
    push_expected();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
  endtask

  // Drops clearn between edges; the check lands on the negedge before any posedge.
  task automatic reset_pulse();
    clearn = 1'b0;
    model_reset();
    push_expected();
    @(posedge clock);
    cyc++;
    #1;
    clearn = 1'b1;
  endtask

  initial begin : monitor
    exp_t         e;
    logic [W-1:0] a_dg;
    logic         a_z, a_t, a_r, a_d;
    forever begin
      @(negedge clock);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.unit == 0) begin
          a_dg = digits0; a_z = zero0; a_t = tc0; a_r = running0; a_d = done0;
        end else begin
          a_dg = digits1; a_z = zero1; a_t = tc1; a_r = running1; a_d = done1;
        end
        checks++;
        if ({a_dg, a_z, a_t, a_r, a_d} !== {e.dg, e.z, e.t, e.r, e.d}) begin
          errors++;
          $display("FAIL wrap%0d cyc%0d digits/zero/tc/running/done got %h/%b/%b/%b/%b exp %h/%b/%b/%b/%b",
                   e.unit, e.cyc, a_dg, a_z, a_t, a_r, a_d, e.dg, e.z, e.t, e.r, e.d);
        end
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] rd;
    int           sel;
    logic         rdir;
    clearn = 1'b0;
    data   = '0;
    loadn  = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    dir    = 1'b0;
    en     = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_pulse();

    // Countdown from 3 into DONE (WRAP=0) / wrap to 9999 (WRAP=1).
    cycle(1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Load in DONE returns to IDLE; then borrow and carry chains.
    cycle(1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0999, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stop with en held, resume, start+stop together in IDLE.
    cycle(1'b0, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clamped load while running with en high.
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'hA5F2, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset mid-run at 0042.
    cycle(1'b0, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_pulse();
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized phase, biased toward terminal values.
    rdir = 1'b0;
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: rd = 16'h0000;
        1: rd = 16'h9999;
        2: rd = 16'h0001;
        3: rd = 16'h9998;
        default: rd = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) rdir = ~rdir;
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end else begin
        cycle(($urandom_range(0, 11) != 0), rd, ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 11) == 0), rdir, ($urandom_range(0, 2) != 0));
      end
    end

    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_timer_counter.md
Name: bcd_timer_counter

Overview:
- Parametrised multi-digit BCD timer/counter: DIGITS cascaded mod-10 digits with a run-control state machine.
- Counts down or up on a tick enable, supports synchronous load, and either wraps or stops at a terminal value.
- Drives the timer display path (one 4-bit BCD nibble per digit) and raises done/tc flags for the control FSM.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); value width is 4*DIGITS bits.
- WRAP, 0, 1 = free-running wrap (down: 0 -> all 9s; up: all 9s -> 0); 0 = stop at terminal value and enter DONE.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clearn  in  1  asynchronous active-low reset.
- data  in  4*DIGITS  BCD load value; digit 0 = bits [3:0] (least significant).
- loadn  in  1  synchronous active-low load of data.
- start  in  1  level; enters RUN from IDLE or DONE.
- stop  in  1  level; returns to IDLE (pause) from RUN.
- dir  in  1  0 = count down, 1 = count up; sampled every tick.
- en  in  1  count tick strobe (e.g. 1 Hz prescaler); counts only in RUN.
- digits  out  4*DIGITS  current BCD value.
- zero  out  1  combinational; 1 when every digit is 0.
- tc  out  1  combinational; 1 when en && RUN && the value is at the terminal for dir (down: all 0; up: all 9).
- running  out  1  registered; 1 in RUN.
- done  out  1  registered one-cycle pulse on entry to DONE.

Behaviour:
- Reset (clearn low, asynchronous): digits = 0, state = IDLE, running = 0, done = 0. Outputs hold while clearn is low.
- States:
  - IDLE: counter frozen.
  - RUN: counter advances on en.
  - DONE: frozen at the terminal value. DONE is reachable only when WRAP = 0.
- Per-cycle priority: loadn > stop > start > count.
- Load (loadn = 0):
  - digits <= data in the same edge, regardless of state.
  - Any nibble > 9 is stored as 9.
  - A load in DONE returns the state to IDLE. A load in RUN keeps RUN but suppresses counting that cycle.
- Transitions:
  - IDLE->RUN on start.
  - RUN->IDLE on stop.
  - DONE->RUN on start. In that case, if the value is still terminal and WRAP = 0, the next tick re-enters DONE immediately with no counting.
- Counting (RUN && en): digit k updates only if all lower digits are at their borrow/carry value.
  - Borrow value is 0 when counting down; carry value is 9 when counting up.
  - Digit 0 always updates.
  - Down: 0 -> 9, else -1. Up: 9 -> 0, else +1.
- Terminal tick with WRAP = 0 (down at all 0, or up at all 9):
  - Value does not change.
  - State goes RUN->DONE; done pulses high for exactly the next cycle; running falls the same edge.
- Terminal tick with WRAP = 1: value wraps, state stays RUN, tc is high during that tick cycle.
- Simultaneous start and stop in IDLE: stop wins, so the state stays IDLE.
- A dir change mid-run takes effect on the next tick with no glitch; the value is never outside BCD.
- Latency: value and state change on the posedge where the en/loadn/start condition is sampled. zero and tc reflect the current registered value combinationally.
- Invalid nibbles (>9) can only arise from load, which clamps them. The counter must still map any nibble > 9 to 9 on the next count as a safety default.

Test Plan:
- DIGITS = 4, WRAP = 0, reset then load 0x0003, start, 3 ticks -> digits 0002, 0001, 0000. The 4th tick raises tc and enters DONE; done is high for 1 cycle, running = 0, digits stay 0000.
- Borrow chain: load 0x1000, start, dir = 0, 1 tick -> 0x0999. Load 0x0999, dir = 1, 1 tick -> 0x1000.
- WRAP = 1: load 0x0000, dir = 0, 1 tick -> 0x9999 with tc high that cycle, state stays RUN. Load 0x9999, dir = 1, 1 tick -> 0x0000.
- Control: stop mid-run at 0x0500 with en held -> value frozen. start -> resumes to 0x0499. Assert start and stop together in IDLE -> stays IDLE.
- Load clamp and priority: load data 0xA5F2 while in RUN with en = 1 -> digits 0x9592 with no decrement that cycle. Load in DONE -> state IDLE.
- Async reset: pulse clearn low between clock edges while in RUN at 0x0042 -> digits 0000, IDLE, running = 0 immediately, with no clock edge needed.
